// File: rtl/u409_pkg.sv
// Shared decode constants, state encoding and select vector for the U409 cycle decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package u409_pkg;

  // A[31:16] value of the Zorro III AUTOCONFIG space
  localparam logic [15:0] AC_SPACE_HI = 16'hFF00;

  // Window sizes as log2 of bytes: LIDE 128K, bridge 64K, Prometheus 256MB
  localparam int LIDE_WIN_LG2   = 17;
  localparam int BRIDGE_WIN_LG2 = 16;
  localparam int PRO_WIN_LG2    = 28;

  // Default ack timeout and counter width (2**CNT_W must exceed the timeout)
  localparam int TIMEOUT_CYC_DEF = 1023;
  localparam int CNT_W_DEF       = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    WAIT   = 2'd2,
    TERM   = 2'd3
  } state_t;

  // One bit per target; at most one bit is ever set
  typedef struct packed {
    logic ac;
    logic lide;
    logic bridge;
    logic pro;
  } sel_t;

  // Mask over A[31:16] covering the address bits above a naturally aligned window
  function automatic logic [15:0] win_mask(input int lg2);
    win_mask = 16'hFFFF << (lg2 - 16);
  endfunction

endpackage

// File: rtl/u409_window_match.sv
// Combinational window compare of a latched A[31:16] against an aligned base and mask.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module u409_window_match (
  input  logic [15:0] addr,
  input  logic [15:0] base,
  input  logic [15:0] mask,
  input  logic        en,
  output logic        hit
);

  // Window hits when enabled and every masked address bit equals the base
  assign hit = en && ((addr & mask) == base);

endmodule

// File: rtl/u409_cycle_decode.sv
// Decodes 68040 cycles onto the U409 targets, holds one select and merges acks into TA/TEA.
// Latency: TSn sampled -> DECODE -> select after the next edge; sampled ack -> TA_OUT after that edge.
// Backpressure: one cycle in flight; TSn while BUSY is ignored, silent targets are ended by TEA.
module u409_cycle_decode
  import u409_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        CLK40,
  input  logic        RESETn,
  input  logic        TSn,
  input  logic [15:0] A,
  input  logic        CONFIGURED,
  input  logic [7:0]  BRIDGE_BASE,
  input  logic [6:0]  LIDE_BASE,
  input  logic [2:0]  PRO_BASE,
  input  logic        AC_TACK,
  input  logic        LIDE_ACK,
  input  logic        BRIDGE_ACK,
  input  logic        PRO_ACK,
  output logic        AUTOCONFIG_SPACE,
  output logic        AC_SEL,
  output logic        LIDE_SEL,
  output logic        BRIDGE_SEL,
  output logic        PRO_SEL,
  output logic        TA_OUT,
  output logic        TEA_OUT,
  output logic        BUSY
);

  localparam logic [15:0]      LIDE_MASK   = win_mask(LIDE_WIN_LG2);
  localparam logic [15:0]      BRIDGE_MASK = win_mask(BRIDGE_WIN_LG2);
  localparam logic [15:0]      PRO_MASK    = win_mask(PRO_WIN_LG2);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC);

  state_t            state_q, state_d;
  sel_t              sel_q, sel_d;
  logic [15:0]       a_q, a_d;
  logic              cfg_q, cfg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ta_q, ta_d;
  logic              tea_q, tea_d;
  logic              hit_ac, hit_lide, hit_bridge, hit_pro;
  logic              ack_hit;

  // Live AUTOCONFIG space flag for the AUTOCONFIG stage, independent of reset
  assign AUTOCONFIG_SPACE = (A == AC_SPACE_HI) && !CONFIGURED;

  // Window compares run on the address and CONFIGURED captured at TSn
  u409_window_match u_win_ac (
    .addr (a_q),
    .base (AC_SPACE_HI),
    .mask (16'hFFFF),
    .en   (!cfg_q),
    .hit  (hit_ac)
  );

  u409_window_match u_win_lide (
    .addr (a_q),
    .base ({LIDE_BASE, 9'd0}),
    .mask (LIDE_MASK),
    .en   (cfg_q),
    .hit  (hit_lide)
  );

  u409_window_match u_win_bridge (
    .addr (a_q),
    .base ({BRIDGE_BASE, 8'd0}),
    .mask (BRIDGE_MASK),
    .en   (cfg_q),
    .hit  (hit_bridge)
  );

  u409_window_match u_win_pro (
    .addr (a_q),
    .base ({PRO_BASE, 13'd0}),
    .mask (PRO_MASK),
    .en   (cfg_q),
    .hit  (hit_pro)
  );

  // Only the ack of the currently selected target can end the cycle
  assign ack_hit = (sel_q.ac     & AC_TACK)
                 | (sel_q.lide   & LIDE_ACK)
                 | (sel_q.bridge & BRIDGE_ACK)
                 | (sel_q.pro    & PRO_ACK);

  // Next-state and next-output logic of the cycle tracker
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    a_d     = a_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    ta_d    = 1'b0;
    tea_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!TSn) begin
          a_d     = A;
          cfg_d   = CONFIGURED;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // Fixed priority AC > LIDE > BRIDGE > PRO; no hit means another board owns the cycle
        sel_d   = '0;
        cnt_d   = '0;
        state_d = WAIT;
        if (hit_ac) begin
          sel_d.ac = 1'b1;
        end else if (hit_lide) begin
          sel_d.lide = 1'b1;
        end else if (hit_bridge) begin
          sel_d.bridge = 1'b1;
        end else if (hit_pro) begin
          sel_d.pro = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Ack is tested before the timeout so a same-cycle ack still yields TA
        if (ack_hit) begin
          sel_d   = '0;
          ta_d    = 1'b1;
          state_d = TERM;
        end else if (cnt_q == TMO_LAST) begin
          sel_d   = '0;
          tea_d   = 1'b1;
          state_d = TERM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TERM: begin
        state_d = IDLE;
      end
      default: begin
        sel_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, capture and output registers with synchronous active-low reset
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      a_q     <= '0;
      cfg_q   <= 1'b0;
      cnt_q   <= '0;
      ta_q    <= 1'b0;
      tea_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      ta_q    <= ta_d;
      tea_q   <= tea_d;
    end
  end

  assign AC_SEL     = sel_q.ac;
  assign LIDE_SEL   = sel_q.lide;
  assign BRIDGE_SEL = sel_q.bridge;
  assign PRO_SEL    = sel_q.pro;
  assign TA_OUT     = ta_q;
  assign TEA_OUT    = tea_q;
  assign BUSY       = (state_q != IDLE);

endmodule
